// File: rtl/ts_par_rx.sv
// Parallel TS receiver: hunts for sync bytes, verifies packet cadence, and forwards aligned packets once locked.
// Optional statistics counters are built when TSIF_RX_STATS_EN is defined; otherwise those ports are tied to 0.
module ts_par_rx #(
  parameter int         PKT_LEN    = 188,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3,
  parameter logic [7:0] SYNC_BYTE  = 8'h47
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ts_par_data_i,
  input  logic        ts_par_sync_i,
  input  logic        ts_par_valid_i,
  output logic [7:0]  pkt_data_o,
  output logic        pkt_sop_o,
  output logic        pkt_eop_o,
  output logic        pkt_valid_o,
  output logic        pkt_err_o,
  output logic        locked_o,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] sync_err_cnt_o
);

  localparam int             CW     = $clog2(PKT_LEN);
  localparam logic [CW-1:0]  LAST   = CW'(PKT_LEN - 1);
  localparam logic [3:0]     LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0]     UNLK_N = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]    good_q, good_d;
  logic [3:0]    bad_q, bad_d;
  logic          err_q, err_d;
  logic [7:0]    data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          perr_q, perr_d;
  logic          vld_q, vld_d;
  logic          fwd;
  logic          good_sync;
  logic          stray_sync;
  logic          bad_pos;

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c);
    return (c == LAST) ? '0 : c + 1'b1;
  endfunction

  assign good_sync = ts_par_valid_i && ts_par_sync_i && (ts_par_data_i == SYNC_BYTE);

  // Transition and output decision both come from the pre-edge state.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = err_q;
    fwd        = 1'b0;
    stray_sync = 1'b0;
    bad_pos    = 1'b0;
    if (ts_par_valid_i) begin
      case (state_q)
        HUNT: begin
          if (good_sync) begin
            byte_cnt_d = CW'(1);
            good_d     = 4'd1;
            bad_d      = 4'd0;
            if (LOCK_N == 4'd1) begin
              state_d = LOCKED;
              fwd     = 1'b1;
              err_d   = 1'b0;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (byte_cnt_q == '0) begin
            if (good_sync) begin
              good_d     = good_q + 4'd1;
              byte_cnt_d = CW'(1);
              if (good_q + 4'd1 == LOCK_N) begin
                state_d = LOCKED;
                fwd     = 1'b1;
                err_d   = 1'b0;
                bad_d   = 4'd0;
              end
            end else begin
              // A bad byte here cannot be a good HUNT sync either, so it is simply dropped.
              state_d    = HUNT;
              byte_cnt_d = '0;
              good_d     = 4'd0;
            end
          end else if (good_sync) begin
            byte_cnt_d = CW'(1);
            good_d     = 4'd1;
          end else begin
            byte_cnt_d = cnt_next(byte_cnt_q);
          end
        end
        LOCKED: begin
          fwd        = 1'b1;
          byte_cnt_d = cnt_next(byte_cnt_q);
          if (byte_cnt_q == '0) begin
            if (good_sync) begin
              bad_d = 4'd0;
              err_d = 1'b0;
            end else begin
              bad_pos = 1'b1;
              if (bad_q + 4'd1 == UNLK_N) begin
                state_d    = HUNT;
                byte_cnt_d = '0;
                good_d     = 4'd0;
                bad_d      = 4'd0;
                fwd        = 1'b0;
              end else begin
                bad_d = bad_q + 4'd1;
                err_d = 1'b1;
              end
            end
          end else if (ts_par_sync_i) begin
            stray_sync = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    data_d = 8'h00;
    sop_d  = 1'b0;
    eop_d  = 1'b0;
    perr_d = 1'b0;
    vld_d  = fwd;
    if (fwd) begin
      data_d = ts_par_data_i;
      sop_d  = (byte_cnt_q == '0);
      eop_d  = (byte_cnt_q == LAST);
      perr_d = err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      byte_cnt_q <= '0;
      good_q     <= 4'd0;
      bad_q      <= 4'd0;
      err_q      <= 1'b0;
      data_q     <= 8'h00;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      perr_q     <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      perr_q     <= perr_d;
      vld_q      <= vld_d;
    end
  end

  assign pkt_data_o  = data_q;
  assign pkt_sop_o   = sop_q;
  assign pkt_eop_o   = eop_q;
  assign pkt_err_o   = perr_q;
  assign pkt_valid_o = vld_q;
  assign locked_o    = (state_q == LOCKED);

`ifdef TSIF_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] serr_cnt_q, serr_cnt_d;

  // Both counters saturate and only clear on reset.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    serr_cnt_d = serr_cnt_q;
    if (fwd && eop_d && pkt_cnt_q != 16'hFFFF)
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    if ((bad_pos || stray_sync) && serr_cnt_q != 16'hFFFF)
      serr_cnt_d = serr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= 16'd0;
      serr_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      serr_cnt_q <= serr_cnt_d;
    end
  end

  assign pkt_cnt_o      = pkt_cnt_q;
  assign sync_err_cnt_o = serr_cnt_q;
`else
  logic unused_stats_ev;
  assign unused_stats_ev = stray_sync ^ bad_pos;
  assign pkt_cnt_o       = 16'd0;
  assign sync_err_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_ts_par_rx.sv
// Directed bench for ts_par_rx: expected output bytes are queued as stimulus is driven and checked one clock later.
module tb_ts_par_rx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ts_par_data_i;
  logic        ts_par_sync_i;
  logic        ts_par_valid_i;
  logic [7:0]  pkt_data_o;
  logic        pkt_sop_o;
  logic        pkt_eop_o;
  logic        pkt_valid_o;
  logic        pkt_err_o;
  logic        locked_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] sync_err_cnt_o;

  ts_par_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ts_par_data_i  (ts_par_data_i),
    .ts_par_sync_i  (ts_par_sync_i),
    .ts_par_valid_i (ts_par_valid_i),
    .pkt_data_o     (pkt_data_o),
    .pkt_sop_o      (pkt_sop_o),
    .pkt_eop_o      (pkt_eop_o),
    .pkt_valid_o    (pkt_valid_o),
    .pkt_err_o      (pkt_err_o),
    .locked_o       (locked_o),
    .pkt_cnt_o      (pkt_cnt_o),
    .sync_err_cnt_o (sync_err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pkt_seed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then compare the registered output one clock later.
  task automatic send_byte(input logic [7:0] d, input logic s, input logic v,
                           input logic fwd, input logic sop, input logic eop, input logic err);
    exp_t e;
    ts_par_data_i  = d;
    ts_par_sync_i  = s;
    ts_par_valid_i = v;
    if (fwd) sb.push_back('{d: d, sop: sop, eop: eop, err: err});
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out_byte", {19'd0, pkt_valid_o, pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_err_o},
          {19'd0, 1'b1, e.d, e.sop, e.eop, e.err});
    end else begin
      chk("no_out", {31'd0, pkt_valid_o}, 32'd0);
    end
  endtask

  // Gap cycles present a perfect sync byte with valid low; it must be ignored.
  task automatic gap_cycles(input bit en);
    if (en && $urandom_range(0, 5) == 0) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++)
        send_byte(8'h47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic fwd, input logic err,
                          input logic exp_lock, input int nbytes, input bit gaps);
    logic [7:0] d;
    pkt_seed++;
    for (int i = 0; i < nbytes; i++) begin
      gap_cycles(gaps);
      d = (i == 0) ? b0 : 8'(i * 3 + pkt_seed * 17);
      send_byte(d, (i == 0), 1'b1, fwd, (i == 0), (i == 187), err);
      if (i == 0) chk("locked_after_sop", {31'd0, locked_o}, {31'd0, exp_lock});
    end
  endtask

  task automatic do_reset();
    ts_par_data_i  = 8'h00;
    ts_par_sync_i  = 1'b0;
    ts_par_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input int pkts, input int serrs);
`ifdef TSIF_RX_STATS_EN
    chk({tag, "_pkt_cnt"}, {16'd0, pkt_cnt_o}, 32'(pkts));
    chk({tag, "_sync_err_cnt"}, {16'd0, sync_err_cnt_o}, 32'(serrs));
`else
    chk({tag, "_pkt_cnt"}, {16'd0, pkt_cnt_o}, 32'd0);
    chk({tag, "_sync_err_cnt"}, {16'd0, sync_err_cnt_o}, 32'd0);
    if (pkts < 0 || serrs < 0) chk("stats_args", 32'd0, 32'd1);
`endif
  endtask

  initial begin
    ts_par_data_i  = 8'h00;
    ts_par_sync_i  = 1'b0;
    ts_par_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {19'd0, pkt_valid_o, pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_err_o}, 32'd0);
    chk("reset_locked", {31'd0, locked_o}, 32'd0);
    chk_stats("reset", 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Clean stream: lock on packet 3, forward packets 3..5.
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);
    chk_stats("clean", 3, 0);

    // Same stream with random valid gaps.
    do_reset();
    chk("relock_after_reset", {31'd0, locked_o}, 32'd0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b1);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b1);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b1);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b1);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b1);
    chk_stats("gapped", 3, 0);

    // Single corrupt sync while locked, then recovery.
    send_pkt(8'h46, 1'b1, 1'b1, 1'b1, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);
    chk_stats("one_bad", 5, 1);

    // Three corrupt syncs: two forwarded with err, third drops lock.
    send_pkt(8'h46, 1'b1, 1'b1, 1'b1, 188, 1'b0);
    send_pkt(8'h00, 1'b1, 1'b1, 1'b1, 188, 1'b0);
    chk_stats("two_bad", 7, 3);
    send_pkt(8'h46, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);

    // False sync at offset 50, true packets from offset 100.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) send_byte(8'h47, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else         send_byte(8'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("false_sync_no_lock", {31'd0, locked_o}, 32'd0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);

    // Reset in the middle of a locked packet.
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 90, 1'b0);
    ts_par_data_i  = 8'h47;
    ts_par_sync_i  = 1'b0;
    ts_par_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {19'd0, pkt_valid_o, pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_err_o}, 32'd0);
    chk("midreset_locked", {31'd0, locked_o}, 32'd0);
    chk_stats("midreset", 0, 0);
    do_reset();
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 188, 1'b0);
    send_pkt(8'h47, 1'b1, 1'b0, 1'b1, 188, 1'b0);
    chk_stats("after_reset", 1, 0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
